// File: rtl/kws_feature_fifo.sv
// kws_feature_fifo: input feature buffer ahead of the cmvn stage.
//
// This is a first-word-fall-through circular FIFO of feature words. Each popped word
// carries its element index within the frame, and a pulse marks the end of each frame.
// Optional feature: define KWS_FIFO_WATERMARK_EN to enable the registered watermark
// flag. When the macro is undefined, wm_hit_o is tied to 0 and wm_i is ignored.
//
// Ports
//   wb_clk_i, wb_rst_i     clock (rising edge); asynchronous active-high reset
//   clr_i                  synchronous flush of pointers, index and sticky flags
//   wr_valid_i, wr_data_i  push request and the word to push
//   wr_ready_o             push accepted when high (= !full)
//   out_valid_o            head word valid (= !empty)
//   out_ready_i            consumer pops the head word
//   out_data_o             head-of-FIFO word
//   out_addr_o             element index of the head word within its frame
//   frame_done_o           one-cycle pulse after the last element of a frame is popped
//   level_o, full_o, empty_o  occupancy status, derived from registered state only
//   ovf_o                  sticky flag: a push was attempted while full
//   wm_i, wm_hit_o         watermark threshold and flag (level >= wm_i)
module kws_feature_fifo #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned FEAT_DIM = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LVL_W    = 7
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              clr_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              frame_done_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_o,
    input  logic [LVL_W-1:0]  wm_i,
    output logic              wm_hit_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic              fdone_q, fdone_d;

    logic full, empty, push, pop, last_elem;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign last_elem = (addr_q == ADDR_W'(FEAT_DIM - 1));

    // Clear takes priority, so neither handshake is allowed to fire while it is asserted.
    assign push = wr_valid_i & ~full & ~clr_i;
    assign pop  = out_ready_i & ~empty & ~clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        addr_d   = addr_q;
        ovf_d    = ovf_q;
        fdone_d  = 1'b0;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            addr_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                addr_d   = last_elem ? '0 : addr_q + ADDR_W'(1);
                fdone_d  = last_elem;
            end
            if (push && !pop) level_d = level_q + LVL_W'(1);
            if (pop && !push) level_d = level_q - LVL_W'(1);
            if (wr_valid_i && full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            fdone_q  <= fdone_d;
        end
    end

    // Storage carries no reset; contents are only meaningful between the pointers.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign wr_ready_o   = ~full;
    assign out_valid_o  = ~empty;
    assign out_data_o   = mem_q[rd_ptr_q];
    assign out_addr_o   = addr_q;
    assign frame_done_o = fdone_q;
    assign level_o      = level_q;
    assign full_o       = full;
    assign empty_o      = empty;
    assign ovf_o        = ovf_q;

`ifdef KWS_FIFO_WATERMARK_EN
    logic wm_hit_q;

    // Compared against the next level so the flag tracks the edge at which level changes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wm_hit_q <= 1'b0;
        end else begin
            wm_hit_q <= (level_d >= wm_i);
        end
    end

    assign wm_hit_o = wm_hit_q;
`else
    logic unused_wm;

    assign unused_wm = ^wm_i;
    assign wm_hit_o  = 1'b0;
`endif

endmodule

// File: tb/tb_kws_feature_fifo.sv
module tb_kws_feature_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        frame_done;
    logic [6:0]  level;
    logic        full;
    logic        empty;
    logic        ovf;
    logic [6:0]  wm;
    logic        wm_hit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kws_feature_fifo dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .clr_i        (clr),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_addr_o   (out_addr),
        .frame_done_o (frame_done),
        .level_o      (level),
        .full_o       (full),
        .empty_o      (empty),
        .ovf_o        (ovf),
        .wm_i         (wm),
        .wm_hit_o     (wm_hit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; out_ready = 1'b0; wm = 7'd16;
        tick();
        tick();

        // Reset values
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", out_valid, 0);
        check("rst_wready", wr_ready, 1);
        check("rst_ovf", ovf, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_addr", out_addr, 0);
        check("rst_wm", wm_hit, 0);
        rst = 1'b0;
        tick();

        // Back-to-back pushes, consumer stalled; first word falls through
        wr_valid = 1'b1;
        wr_data = 32'hA0; tick();
        check("fwft_valid", out_valid, 1);
        check("fwft_data", out_data, 32'hA0);
        wr_data = 32'hA1; tick();
        wr_data = 32'hA2; tick();
        wr_valid = 1'b0;
        check("a_level", level, 3);
        check("a_data", out_data, 32'hA0);
        check("a_addr", out_addr, 0);
        check("a_empty", empty, 0);
        tick();
        check("a_stable", out_data, 32'hA0);

        // Fill to full, then an overflowing push of 0xDEAD
        clear();
        check("clr_empty", empty, 1);
        for (int i = 0; i < 64; i++) push(32'h100 + i);
        check("f_level", level, 64);
        check("f_full", full, 1);
        check("f_wready", wr_ready, 0);
        check("f_ovf0", ovf, 0);
        push(32'hDEAD);
        check("f_ovf", ovf, 1);
        check("f_level2", level, 64);

        // Drain continuously: order, frame index, frame_done pulses
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("d_data%0d", i), out_data, 32'h100 + i);
            check($sformatf("d_addr%0d", i), out_addr, i % 32);
            tick();
            check($sformatf("d_fdone%0d", i), frame_done, (i % 32) == 31);
        end
        out_ready = 1'b0;
        check("d_empty", empty, 1);
        check("d_valid", out_valid, 0);
        check("d_ovf_sticky", ovf, 1);
        tick();
        check("d_fdone_off", frame_done, 0);

        // Full with simultaneous pop: push still refused, no combinational ready path
        clear();
        check("clr_ovf", ovf, 0);
        for (int i = 0; i < 64; i++) push(32'h200 + i);
        wr_valid = 1'b1; wr_data = 32'hBEEF; out_ready = 1'b1;
        tick();
        wr_valid = 1'b0; out_ready = 1'b0;
        check("fp_level", level, 63);
        check("fp_head", out_data, 32'h201);
        check("fp_ovf", ovf, 1);

        // Level 5, push and pop together
        clear();
        for (int i = 0; i < 5; i++) push(32'h300 + i);
        wr_valid = 1'b1; wr_data = 32'h3AA; out_ready = 1'b1;
        tick();
        wr_valid = 1'b0; out_ready = 1'b0;
        check("pp_level", level, 5);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("pp_data%0d", i), out_data, 32'h300 + i);
            pop();
        end
        check("pp_last", out_data, 32'h3AA);
        pop();
        check("pp_empty", empty, 1);

        // Clear wins over simultaneous push and pop
        clear();
        for (int i = 0; i < 17; i++) push(32'h400 + i);
        for (int i = 0; i < 7; i++) pop();
        check("c_level10", level, 10);
        check("c_addr7", out_addr, 7);
        clr = 1'b1; wr_valid = 1'b1; wr_data = 32'h4FF; out_ready = 1'b1;
        tick();
        clr = 1'b0; wr_valid = 1'b0; out_ready = 1'b0;
        check("c_level", level, 0);
        check("c_addr", out_addr, 0);
        check("c_ovf", ovf, 0);
        check("c_empty", empty, 1);
        check("c_fdone", frame_done, 0);

        // Watermark at 16
        for (int i = 0; i < 15; i++) push(32'h500 + i);
        check("wm_below", wm_hit, 0);
        push(32'h50F);
`ifdef KWS_FIFO_WATERMARK_EN
        check("wm_rise", wm_hit, 1);
`else
        check("wm_tied", wm_hit, 0);
`endif
        pop();
        check("wm_fall", wm_hit, 0);
        check("wm_level", level, 15);

        // Asynchronous reset mid-frame
        clear();
        for (int i = 0; i < 3; i++) push(32'h600 + i);
        pop();
        check("r_addr1", out_addr, 1);
        #2 rst = 1'b1;
        #1;
        check("r_level", level, 0);
        check("r_addr", out_addr, 0);
        check("r_empty", empty, 1);
        check("r_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        push(32'h700);
        check("r_restart", out_data, 32'h700);
        check("r_addr0", out_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
